// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus bundle: display fetch port, CPU slave port and
// the RAM macro port. The arbiter uses the slave view; its environment
// (pixel fetch, CPU bridge, RAM) uses the master view.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [3:0]        cpu_be;
   logic              cpu_gnt;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              cpu_err;

   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  disp_req, disp_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      input  ram_rdata,
      output disp_gnt, disp_rdata, disp_rvalid,
      output cpu_gnt, cpu_rdata, cpu_ready, cpu_err,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output disp_req, disp_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      output ram_rdata,
      input  disp_gnt, disp_rdata, disp_rvalid,
      input  cpu_gnt, cpu_rdata, cpu_ready, cpu_err,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: shares one single-port synchronous RAM between
// the VGA prefetch path (priority) and the CPU slave (read/write). Every
// access is IDLE -> ISSUE -> CAPTURE -> IDLE; the CPU is guaranteed a grant
// after CPU_MAX_WAIT consecutive display wins while it is waiting.
module vga_fb_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 32,
   parameter int FB_WORDS     = 9600,
   parameter int CPU_MAX_WAIT = 8
) (
   input logic             CLOCK_50,
   input logic             nReset,
   vga_fb_arbiter_if.slave bus
);
   localparam int WC_W = $clog2(CPU_MAX_WAIT + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   localparam logic [WC_W-1:0]   WAIT_MAX = WC_W'(CPU_MAX_WAIT);
   localparam logic [WC_W-1:0]   WAIT_ONE = WC_W'(1);
   localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

   logic [1:0]        state_r;
   logic [WC_W-1:0]   wait_cnt_r;
   logic              own_cpu_r;   // access in flight belongs to the CPU
   logic              acc_we_r;    // CPU access in flight is a write
   logic              acc_err_r;   // CPU access in flight is out of range

   logic              disp_gnt_r;
   logic [DATA_W-1:0] disp_rdata_r;
   logic              disp_rvalid_r;
   logic              cpu_gnt_r;
   logic [DATA_W-1:0] cpu_rdata_r;
   logic              cpu_ready_r;
   logic              cpu_err_r;
   logic              ram_en_r;
   logic [3:0]        ram_we_r;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [DATA_W-1:0] ram_wdata_r;

   logic              disp_win_s;
   logic              cpu_win_s;
   logic              cpu_oor_s;

   // Arbitration: a starved CPU beats the display, otherwise display first.
   always_comb begin
      disp_win_s = 1'b0;
      cpu_win_s  = 1'b0;
      cpu_oor_s  = (bus.cpu_addr >= FB_LIMIT);
      if (state_r == ST_IDLE) begin
         if (bus.cpu_req && (wait_cnt_r >= WAIT_MAX)) begin
            cpu_win_s = 1'b1;
         end else if (bus.disp_req) begin
            disp_win_s = 1'b1;
         end else if (bus.cpu_req) begin
            cpu_win_s = 1'b1;
         end else begin
            cpu_win_s = 1'b0;
         end
      end else begin
         disp_win_s = 1'b0;
      end
   end

   // Access sequencer and the attributes of the access in flight.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         state_r   <= ST_IDLE;
         own_cpu_r <= 1'b0;
         acc_we_r  <= 1'b0;
         acc_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (disp_win_s || cpu_win_s) begin
                  state_r   <= ST_ISSUE;
                  own_cpu_r <= cpu_win_s;
                  acc_we_r  <= cpu_win_s & bus.cpu_we;
                  acc_err_r <= cpu_win_s & cpu_oor_s;
               end
            end
            ST_ISSUE:   state_r <= ST_CAPTURE;
            ST_CAPTURE: state_r <= ST_IDLE;
            default:    state_r <= ST_IDLE;
         endcase
      end
   end

   // CPU starvation counter: counts display wins over a waiting CPU.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         wait_cnt_r <= '0;
      end else if (cpu_win_s) begin
         wait_cnt_r <= '0;
      end else if (disp_win_s && bus.cpu_req && (wait_cnt_r < WAIT_MAX)) begin
         wait_cnt_r <= wait_cnt_r + WAIT_ONE;
      end
   end

   // RAM port: driven for exactly the ISSUE cycle; address/data hold after.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         ram_en_r    <= 1'b0;
         ram_we_r    <= 4'b0000;
         ram_addr_r  <= '0;
         ram_wdata_r <= '0;
      end else if (disp_win_s) begin
         ram_en_r   <= 1'b1;
         ram_we_r   <= 4'b0000;
         ram_addr_r <= bus.disp_addr;
      end else if (cpu_win_s && !cpu_oor_s) begin
         ram_en_r   <= 1'b1;
         ram_we_r   <= bus.cpu_we ? bus.cpu_be : 4'b0000;
         ram_addr_r <= bus.cpu_addr;
         if (bus.cpu_we) begin
            ram_wdata_r <= bus.cpu_wdata;
         end
      end else begin
         // Idle, in flight, or an out-of-range CPU access: RAM untouched.
         ram_en_r <= 1'b0;
         ram_we_r <= 4'b0000;
      end
   end

   // Grant pulses: one cycle, coincident with the ISSUE state.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         disp_gnt_r <= 1'b0;
         cpu_gnt_r  <= 1'b0;
      end else begin
         disp_gnt_r <= disp_win_s;
         cpu_gnt_r  <= cpu_win_s;
      end
   end

   // Completion: capture RAM data at the end of CAPTURE and pulse the owner.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         disp_rdata_r  <= '0;
         disp_rvalid_r <= 1'b0;
         cpu_rdata_r   <= '0;
         cpu_ready_r   <= 1'b0;
         cpu_err_r     <= 1'b0;
      end else if (state_r == ST_CAPTURE) begin
         if (own_cpu_r) begin
            disp_rvalid_r <= 1'b0;
            cpu_ready_r   <= 1'b1;
            cpu_err_r     <= acc_err_r;
            if (!acc_we_r) begin
               cpu_rdata_r <= acc_err_r ? '0 : bus.ram_rdata;
            end
         end else begin
            disp_rdata_r  <= bus.ram_rdata;
            disp_rvalid_r <= 1'b1;
            cpu_ready_r   <= 1'b0;
            cpu_err_r     <= 1'b0;
         end
      end else begin
         disp_rvalid_r <= 1'b0;
         cpu_ready_r   <= 1'b0;
         cpu_err_r     <= 1'b0;
      end
   end

   assign bus.disp_gnt    = disp_gnt_r;
   assign bus.disp_rdata  = disp_rdata_r;
   assign bus.disp_rvalid = disp_rvalid_r;
   assign bus.cpu_gnt     = cpu_gnt_r;
   assign bus.cpu_rdata   = cpu_rdata_r;
   assign bus.cpu_ready   = cpu_ready_r;
   assign bus.cpu_err     = cpu_err_r;
   assign bus.ram_en      = ram_en_r;
   assign bus.ram_we      = ram_we_r;
   assign bus.ram_addr    = ram_addr_r;
   assign bus.ram_wdata   = ram_wdata_r;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a vector table of isolated accesses, hand-written
// contention/starvation/reset sequences, and a randomized run against a
// transaction-level model of the arbitration rules.
module tb_vga_fb_arbiter;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int FB_WORDS = 9600;
   localparam int MAXW = 8;
   localparam int NCYC = 2000;

   logic CLOCK_50 = 1'b0;
   logic nReset;

   vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vga_fb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS), .CPU_MAX_WAIT(MAXW)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .nReset(nReset),
      .bus(bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Frame-buffer RAM macro: synchronous read, byte writes, plus a preload port.
   logic [31:0] ram [0:16383];
   logic        pl_en = 1'b0;
   logic [13:0] pl_addr = 14'd0;
   logic [31:0] pl_data = 32'd0;
   always @(posedge CLOCK_50) begin
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else if (bus.ram_en) begin
         bus.ram_rdata <= ram[bus.ram_addr];
         for (int i = 0; i < 4; i++) begin
            if (bus.ram_we[i]) ram[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en = 1'b1;
      @(negedge CLOCK_50);
      pl_en = 1'b0;
   endtask

   typedef struct {
      bit          cpu;
      bit          we;
      logic [13:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          pre;
      logic [31:0] pre_val;
      bit          exp_en;
      logic [3:0]  exp_we;
      logic [31:0] exp_data;  // read data, or RAM word after a write
      bit          exp_err;
   } vec_t;

   vec_t vecs [12];
   logic [31:0] last_cpu = 32'd0;

   // One isolated access from an idle arbiter, checked cycle by cycle.
   task automatic apply_vec(input int idx, input vec_t v);
      if (v.pre) preload(v.addr, v.pre_val);
      if (v.cpu) begin
         bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr;
         bus.cpu_wdata = v.wdata; bus.cpu_be = v.be;
      end else begin
         bus.disp_req = 1'b1; bus.disp_addr = v.addr;
      end
      @(negedge CLOCK_50);
      chk($sformatf("vec%0d gnt", idx), {bus.disp_gnt, bus.cpu_gnt}, v.cpu ? 2'b01 : 2'b10);
      chk($sformatf("vec%0d ram_en", idx), bus.ram_en, v.exp_en);
      chk($sformatf("vec%0d ram_we", idx), bus.ram_we, v.exp_we);
      if (v.exp_en) chk($sformatf("vec%0d ram_addr", idx), bus.ram_addr, v.addr);
      if (v.exp_en && v.we) chk($sformatf("vec%0d ram_wdata", idx), bus.ram_wdata, v.wdata);
      bus.disp_req = 1'b0;
      bus.cpu_req = 1'b0;
      @(negedge CLOCK_50);
      chk($sformatf("vec%0d quiet", idx),
          {bus.disp_gnt, bus.cpu_gnt, bus.disp_rvalid, bus.cpu_ready, bus.ram_en}, 5'b0);
      @(negedge CLOCK_50);
      if (v.cpu) begin
         chk($sformatf("vec%0d done", idx), {bus.cpu_ready, bus.cpu_err, bus.disp_rvalid},
             {1'b1, v.exp_err, 1'b0});
         if (!v.we) begin
            chk($sformatf("vec%0d cpu_rdata", idx), bus.cpu_rdata, v.exp_data);
            last_cpu = v.exp_data;
         end else begin
            chk($sformatf("vec%0d cpu_rdata hold", idx), bus.cpu_rdata, last_cpu);
            chk($sformatf("vec%0d mem", idx), ram[v.addr], v.exp_data);
         end
      end else begin
         chk($sformatf("vec%0d done", idx), {bus.disp_rvalid, bus.cpu_ready}, 2'b10);
         chk($sformatf("vec%0d disp_rdata", idx), bus.disp_rdata, v.exp_data);
      end
   endtask

   // Randomized-phase expectations, indexed by cycle.
   bit          e_dg [NCYC+4], e_cg [NCYC+4], e_dv [NCYC+4], e_cr [NCYC+4], e_ce [NCYC+4];
   bit          e_en [NCYC+4], e_cka [NCYC+4], e_ckw [NCYC+4];
   logic [3:0]  e_we [NCYC+4];
   logic [13:0] e_ad [NCYC+4];
   logic [31:0] e_wd [NCYC+4], e_dd [NCYC+4], e_cd [NCYC+4];
   logic [31:0] mm [0:63];

   initial begin
      int nd, ncpu;
      int cnt [2];
      int wc, next_t;
      logic [31:0] m_cpu_rd;
      bit forced, dw, cw, bad;
      int a;

      vecs[0]  = '{1'b0, 1'b0, 14'h0010, 32'h0, 4'h0, 1'b1, 32'hA5A50F0F, 1'b1, 4'h0, 32'hA5A50F0F, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 14'd5, 32'h11223344, 4'b0010, 1'b1, 32'h0, 1'b1, 4'b0010, 32'h00003300, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 14'd5, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h00003300, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 14'd7, 32'hDEADBEEF, 4'b1111, 1'b1, 32'h12345678, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 14'd7, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 1'b1, 4'b0000, 32'hDEADBEEF, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 14'd7, 32'hAABBCCDD, 4'b1001, 1'b0, 32'h0, 1'b1, 4'b1001, 32'hAAADBEDD, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 14'd7, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hAAADBEDD, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 14'd9600, 32'h0, 4'h0, 1'b1, 32'h77777777, 1'b0, 4'h0, 32'h0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 14'd16383, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 14'd9600, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h00000055, 1'b0, 4'h0, 32'h00000055, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 14'd9599, 32'h0, 4'h0, 1'b1, 32'h0F0F0001, 1'b1, 4'h0, 32'h0F0F0001, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 14'd9599, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0F0F0001, 1'b0};

      bus.disp_req = 1'b0; bus.disp_addr = 14'd0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd0;
      bus.cpu_wdata = 32'd0; bus.cpu_be = 4'd0;
      nReset = 1'b1;
      #3 nReset = 1'b0;
      #1;
      chk("reset pulses", {bus.disp_gnt, bus.disp_rvalid, bus.cpu_gnt, bus.cpu_ready, bus.cpu_err}, 5'b0);
      chk("reset rdata", {bus.disp_rdata, bus.cpu_rdata}, 64'd0);
      chk("reset ram", {bus.ram_wdata, bus.ram_addr, bus.ram_we, bus.ram_en}, 51'd0);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      nReset = 1'b1;
      @(negedge CLOCK_50);
      chk("idle after reset", {bus.disp_gnt, bus.cpu_gnt, bus.ram_en}, 3'b0);

      // Table of isolated accesses.
      for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

      // Reset during CAPTURE of a display read, then a fresh read.
      bus.disp_req = 1'b1; bus.disp_addr = 14'h0010;
      @(negedge CLOCK_50);
      chk("rst-mid gnt", bus.disp_gnt, 1'b1);
      bus.disp_req = 1'b0;
      @(negedge CLOCK_50);
      nReset = 1'b0;
      #1;
      chk("rst-mid pulses", {bus.disp_gnt, bus.disp_rvalid, bus.cpu_gnt, bus.cpu_ready, bus.cpu_err}, 5'b0);
      chk("rst-mid rdata", {bus.disp_rdata, bus.cpu_rdata}, 64'd0);
      chk("rst-mid ram", {bus.ram_wdata, bus.ram_addr, bus.ram_we, bus.ram_en}, 51'd0);
      @(negedge CLOCK_50);
      chk("rst-mid no rvalid", bus.disp_rvalid, 1'b0);
      nReset = 1'b1;
      bus.disp_req = 1'b1; bus.disp_addr = 14'h0010;
      @(negedge CLOCK_50);
      chk("post-rst gnt", {bus.disp_gnt, bus.ram_en, bus.ram_addr}, {2'b11, 14'h0010});
      bus.disp_req = 1'b0;
      @(negedge CLOCK_50);
      chk("post-rst early", bus.disp_rvalid, 1'b0);
      @(negedge CLOCK_50);
      chk("post-rst rvalid", {bus.disp_rvalid, bus.disp_rdata}, {1'b1, 32'hA5A50F0F});

      // Simultaneous requests with no CPU backlog: display first.
      bus.disp_req = 1'b1; bus.disp_addr = 14'h0010;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd5;
      @(negedge CLOCK_50);
      chk("simul c1", {bus.disp_gnt, bus.cpu_gnt}, 2'b10);
      bus.disp_req = 1'b0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("simul c3", {bus.disp_rvalid, bus.cpu_gnt, bus.disp_rdata}, {2'b10, 32'hA5A50F0F});
      @(negedge CLOCK_50);
      chk("simul c4", {bus.cpu_gnt, bus.disp_gnt}, 2'b10);
      bus.cpu_req = 1'b0;
      @(negedge CLOCK_50);
      chk("simul c5", bus.cpu_ready, 1'b0);
      @(negedge CLOCK_50);
      chk("simul c6", {bus.cpu_ready, bus.cpu_err, bus.cpu_rdata}, {2'b10, 32'h00003300});

      // Starvation: both held; count display grants between CPU grants.
      bus.disp_req = 1'b1; bus.disp_addr = 14'h0010;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd7;
      nd = 0; ncpu = 0; cnt[0] = -1; cnt[1] = -1;
      for (int c = 0; c < 120 && ncpu < 2; c++) begin
         @(negedge CLOCK_50);
         if (bus.cpu_gnt) begin
            cnt[ncpu] = nd;
            ncpu++;
            nd = 0;
         end
         if (bus.disp_gnt) nd++;
      end
      chk("starve cpu grants", 64'(ncpu), 64'd2);
      chk("starve round1", 64'(cnt[0]), 64'd8);
      chk("starve round2", 64'(cnt[1]), 64'd8);
      bus.disp_req = 1'b0; bus.cpu_req = 1'b0;
      repeat (3) @(negedge CLOCK_50);

      // Randomized run against a transaction-level model.
      nReset = 1'b0;
      @(negedge CLOCK_50);
      nReset = 1'b1;
      for (int i = 0; i < 64; i++) begin
         mm[i] = $urandom;
         preload(14'(i), mm[i]);
      end
      for (int i = 0; i < NCYC + 4; i++) begin
         e_dg[i] = 0; e_cg[i] = 0; e_dv[i] = 0; e_cr[i] = 0; e_ce[i] = 0;
         e_en[i] = 0; e_cka[i] = 0; e_ckw[i] = 0; e_we[i] = 4'd0;
         e_ad[i] = 14'd0; e_wd[i] = 32'd0; e_dd[i] = 32'd0; e_cd[i] = 32'd0;
      end
      wc = 0; next_t = 0; m_cpu_rd = 32'd0;
      for (int t = 0; t < NCYC; t++) begin
         @(negedge CLOCK_50);
         chk("rnd pulses", {bus.disp_gnt, bus.cpu_gnt, bus.disp_rvalid, bus.cpu_ready, bus.cpu_err},
             {e_dg[t], e_cg[t], e_dv[t], e_cr[t], e_ce[t]});
         chk("rnd ram_en/we", {bus.ram_en, bus.ram_we}, {e_en[t], e_we[t]});
         if (e_cka[t]) chk("rnd ram_addr", bus.ram_addr, e_ad[t]);
         if (e_ckw[t]) chk("rnd ram_wdata", bus.ram_wdata, e_wd[t]);
         if (e_dv[t]) chk("rnd disp_rdata", bus.disp_rdata, e_dd[t]);
         if (e_cr[t]) chk("rnd cpu_rdata", bus.cpu_rdata, e_cd[t]);

         // Requesters: hold until granted, then drop or go again.
         if (!bus.disp_req) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.disp_req = 1'b1; bus.disp_addr = 14'($urandom_range(0, 63));
            end
         end else if (bus.disp_gnt) begin
            if ($urandom_range(0, 1) == 0) bus.disp_addr = 14'($urandom_range(0, 63));
            else bus.disp_req = 1'b0;
         end
         if (!bus.cpu_req || bus.cpu_gnt) begin
            if (!bus.cpu_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0)) begin
               bus.cpu_req = 1'b1;
               bus.cpu_we = 1'($urandom_range(0, 1));
               bus.cpu_addr = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(9600, 16383))
                                                          : 14'($urandom_range(0, 63));
               bus.cpu_wdata = $urandom;
               bus.cpu_be = 4'($urandom_range(0, 15));
            end else begin
               bus.cpu_req = 1'b0;
            end
         end

         // Model: one access per three cycles, starved CPU first, else display first.
         if (t >= next_t) begin
            forced = bus.cpu_req && (wc >= MAXW);
            cw = forced || (bus.cpu_req && !bus.disp_req);
            dw = bus.disp_req && !forced;
            if (dw) begin
               if (bus.cpu_req && wc < MAXW) wc = wc + 1;
               e_dg[t+1] = 1; e_en[t+1] = 1; e_we[t+1] = 4'd0;
               e_cka[t+1] = 1; e_ad[t+1] = bus.disp_addr;
               e_dv[t+3] = 1; e_dd[t+3] = mm[int'(bus.disp_addr)];
               next_t = t + 3;
            end else if (cw) begin
               wc = 0;
               a = int'(bus.cpu_addr);
               bad = (a >= FB_WORDS);
               e_cg[t+1] = 1; e_en[t+1] = !bad;
               e_we[t+1] = (!bad && bus.cpu_we) ? bus.cpu_be : 4'd0;
               e_cka[t+1] = !bad; e_ad[t+1] = bus.cpu_addr;
               e_ckw[t+1] = !bad && bus.cpu_we; e_wd[t+1] = bus.cpu_wdata;
               if (bus.cpu_we) begin
                  if (!bad) begin
                     for (int b = 0; b < 4; b++)
                        if (bus.cpu_be[b]) mm[a][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
                  end
               end else begin
                  m_cpu_rd = bad ? 32'd0 : mm[a];
               end
               e_cr[t+3] = 1; e_ce[t+3] = bad; e_cd[t+3] = m_cpu_rd;
               next_t = t + 3;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
